// File: rtl/lifo_stack.sv
// Parameterised LIFO stack with zero-latency top-of-stack read.
// Optional sticky overflow/underflow flags enabled by LIFO_STACK_ERR_EN.
module lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    input  logic                       err_clr,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             do_push;
    logic             do_pop;
    logic             do_swap;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign top_idx = AW'(count - CW'(1));
    assign wr_idx  = AW'(count);

    // An empty stack never exposes stale array contents.
    assign dout = empty ? '0 : mem[top_idx];

    // A push+pop on an empty stack degrades to a plain push.
    assign do_push = push && !full && (!pop || empty);
    assign do_pop  = pop && !push && !empty;
    assign do_swap = push && pop && !empty;

    // Occupancy counter; swap leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + CW'(1);
        end else if (do_pop) begin
            count <= count - CW'(1);
        end
    end

    // Storage is not reset; it is only visible through count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (do_push) begin
                mem[wr_idx] <= din;
            end else if (do_swap) begin
                mem[top_idx] <= din;
            end
        end
    end

`ifdef LIFO_STACK_ERR_EN
    logic ovf_set;
    logic unf_set;

    assign ovf_set = push && !pop && full;
    assign unf_set = pop && empty;

    // Sticky error flags; clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) overflow  <= 1'b1;
            if (unf_set) underflow <= 1'b1;
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack (WIDTH=8, DEPTH=4).
// Pop-cycle outputs are compared against a scoreboard of pushed data.
module tb_lifo_stack;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb [$];
    logic [7:0] pop_dout;
    logic [7:0] exp_v;

`ifdef LIFO_STACK_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    lifo_stack #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .dout      (dout),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .err_clr   (err_clr),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // One clock cycle: inputs set at negedge, pop-cycle dout captured
    // before the rising edge, state sampled 1 time unit after it.
    task automatic step(input logic p, input logic q,
                        input logic [7:0] d, input logic c);
        @(negedge clk);
        push = p; pop = q; din = d; err_clr = c;
        #1;
        pop_dout = dout;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    task automatic sb_push(input logic [7:0] d);
        step(1'b1, 1'b0, d, 1'b0);
        sb.push_back(d);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(1'b1, 1'b1, 8'hEE, 1'b0);
        rst = 1'b0;
        sb.delete();
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b dout=%h want 0 1 0 00",
                     count, empty, full, dout);
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ovf=%b unf=%b want 0 0", overflow, underflow);
        end
    endtask

    task automatic test_push_pop;
        sb_push(8'h11);
        sb_push(8'h22);
        sb_push(8'h33);
        checks++;
        if (count !== 3'd3 || dout !== 8'h33 || empty !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL push3: count=%0d dout=%h empty=%b full=%b want 3 33 0 0",
                     count, dout, empty, full);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            exp_v = sb.pop_back();
            checks++;
            if (pop_dout !== exp_v) begin
                errors++;
                $display("FAIL pop_data[%0d]: got %h want %h", i, pop_dout, exp_v);
            end
        end
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || dout !== 8'h00 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL drained: count=%0d empty=%b dout=%h unf=%b want 0 1 00 0",
                     count, empty, dout, underflow);
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 4; i++) sb_push(8'hA0 + 8'(i));
        checks++;
        if (full !== 1'b1 || empty !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL fill: full=%b empty=%b count=%0d want 1 0 4", full, empty, count);
        end
        step(1'b1, 1'b0, 8'hFF, 1'b0);
        checks++;
        if (count !== 3'd4 || dout !== 8'hA3 || overflow !== ERR_EN) begin
            errors++;
            $display("FAIL overflow: count=%0d dout=%h ovf=%b want 4 a3 %b",
                     count, dout, overflow, ERR_EN);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b want 0", overflow);
        end
        step(1'b1, 1'b0, 8'hFE, 1'b1);
        checks++;
        if (overflow !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL clr_priority: ovf=%b count=%0d want 0 4", overflow, count);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            exp_v = sb.pop_back();
            checks++;
            if (pop_dout !== exp_v) begin
                errors++;
                $display("FAIL full_drain[%0d]: got %h want %h", i, pop_dout, exp_v);
            end
        end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (pop_dout !== 8'h00 || count !== 3'd0 || dout !== 8'h00 || underflow !== ERR_EN) begin
            errors++;
            $display("FAIL underflow: popdout=%h count=%0d dout=%h unf=%b want 00 0 00 %b",
                     pop_dout, count, dout, underflow, ERR_EN);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL unf_clear: unf=%b want 0", underflow);
        end
    endtask

    task automatic test_swap;
        sb_push(8'h11);
        sb_push(8'h22);
        step(1'b1, 1'b1, 8'h5A, 1'b0);
        checks++;
        if (pop_dout !== sb[$]) begin
            errors++;
            $display("FAIL swap_popdata: got %h want %h", pop_dout, sb[$]);
        end
        sb[sb.size()-1] = 8'h5A;
        checks++;
        if (count !== 3'd2 || dout !== 8'h5A) begin
            errors++;
            $display("FAIL swap: count=%0d dout=%h want 2 5a", count, dout);
        end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        exp_v = sb.pop_back();
        checks++;
        if (pop_dout !== exp_v || dout !== sb[$]) begin
            errors++;
            $display("FAIL swap_pop: popdout=%h dout=%h want %h %h",
                     pop_dout, dout, exp_v, sb[$]);
        end
        sb_push(8'hC1);
        sb_push(8'hC2);
        sb_push(8'hC3);
        step(1'b1, 1'b1, 8'hD4, 1'b0);
        sb[sb.size()-1] = 8'hD4;
        checks++;
        if (count !== 3'd4 || dout !== 8'hD4 || full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL swap_full: count=%0d dout=%h full=%b ovf=%b want 4 d4 1 0",
                     count, dout, full, overflow);
        end
        while (sb.size() > 0) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            exp_v = sb.pop_back();
            checks++;
            if (pop_dout !== exp_v) begin
                errors++;
                $display("FAIL swap_drain: got %h want %h", pop_dout, exp_v);
            end
        end
    endtask

    task automatic test_empty_swap;
        step(1'b1, 1'b1, 8'h77, 1'b0);
        sb.push_back(8'h77);
        checks++;
        if (count !== 3'd1 || dout !== 8'h77 || underflow !== ERR_EN) begin
            errors++;
            $display("FAIL empty_swap: count=%0d dout=%h unf=%b want 1 77 %b",
                     count, dout, underflow, ERR_EN);
        end
        step(1'b0, 1'b1, 8'h00, 1'b1);
        exp_v = sb.pop_back();
        checks++;
        if (pop_dout !== exp_v || underflow !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL empty_swap_pop: popdout=%h unf=%b empty=%b want %h 0 1",
                     pop_dout, underflow, empty, exp_v);
        end
    endtask

    task automatic test_reset_mid;
        sb_push(8'h01);
        sb_push(8'h02);
        sb_push(8'h03);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        sb.delete();
        sb_push(8'h05);
        sb_push(8'h06);
        sb_push(8'h07);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h99, 1'b0);
        rst = 1'b0;
        sb.delete();
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || dout !== 8'h00 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: count=%0d empty=%b dout=%h ovf=%b unf=%b want 0 1 00 0 0",
                     count, empty, dout, overflow, underflow);
        end
        sb_push(8'h44);
        checks++;
        if (count !== 3'd1 || dout !== 8'h44) begin
            errors++;
            $display("FAIL post_reset_push: count=%0d dout=%h want 1 44", count, dout);
        end
        sb_push(8'h45);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        void'(sb.pop_back());
        checks++;
        if (dout !== 8'h44 || count !== 3'd1) begin
            errors++;
            $display("FAIL post_reset_idx0: dout=%h count=%0d want 44 1", dout, count);
        end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        void'(sb.pop_back());
    endtask

    task automatic test_random;
        logic       p;
        logic       q;
        logic [7:0] d;
        int         n;
        for (int i = 0; i < 300; i++) begin
            p = 1'($urandom_range(0, 1));
            q = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            step(p, q, d, 1'b0);
            n = sb.size();
            if (q && n > 0) begin
                checks++;
                if (pop_dout !== sb[$]) begin
                    errors++;
                    $display("FAIL rand_pop[%0d]: got %h want %h", i, pop_dout, sb[$]);
                end
            end
            if (p && q && n > 0) sb[n-1] = d;
            else if (p && n < 4) sb.push_back(d);
            else if (q && !p && n > 0) void'(sb.pop_back());
            exp_v = (sb.size() > 0) ? sb[$] : 8'h00;
            checks++;
            if (count !== 3'(sb.size()) || dout !== exp_v ||
                empty !== (sb.size() == 0) || full !== (sb.size() == 4)) begin
                errors++;
                $display("FAIL rand_state[%0d]: count=%0d dout=%h e=%b f=%b want %0d %h",
                         i, count, dout, empty, full, sb.size(), exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_swap();
        test_empty_swap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lifo_stack.md
LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (legal range 1..64).
REQ-002 SHALL have parameter DEPTH, default 16, number of storage entries (legal range 2..256).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port push  input  1  write din onto the stack this cycle.
REQ-006 SHALL have port pop  input  1  remove the top entry this cycle.
REQ-007 SHALL have port din  input  WIDTH  data to push.
REQ-008 SHALL have port dout  output  WIDTH  current top entry, combinational from storage; 0 when empty.
REQ-009 SHALL have port count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-010 SHALL have port empty  output  1  high when count==0.
REQ-011 SHALL have port full  output  1  high when count==DEPTH.
REQ-012 SHALL have port err_clr  input  1  clears the error flags.
REQ-013 SHALL have port overflow  output  1  sticky: push rejected because the stack was full.
REQ-014 SHALL have port underflow  output  1  sticky: pop rejected because the stack was empty.

Function
REQ-015 SHALL hold entries in a DEPTH x WIDTH array indexed 0..DEPTH-1, with the top at index count-1.
REQ-016 SHALL present on dout, in the same cycle pop is asserted, the value being popped (zero-latency read, matching the pop-cycle output of the 8-bit stack).
REQ-017 Push only, not full: SHALL write din at index count and increment count at the clock edge.
REQ-018 Pop only, not empty: SHALL decrement count at the clock edge; the popped array entry need not be cleared.
REQ-019 Push and pop together, not empty (including full): SHALL overwrite the top entry with din and leave count unchanged.
REQ-020 Push and pop together, empty: SHALL perform the push (count 0->1) and ignore the pop; underflow SHALL set.
REQ-021 Push only, full: SHALL leave count and storage unchanged; overflow SHALL set.
REQ-022 Pop only, empty: SHALL leave count unchanged; dout SHALL remain 0; underflow SHALL set.
REQ-023 SHALL keep count within 0..DEPTH at all times, with no wrap-around in either direction.
REQ-024 SHALL derive empty and full combinationally from count; both SHALL never be high together.
REQ-025 SHALL give err_clr priority over a same-cycle set: flags read 0 in the next cycle.
REQ-026 SHALL ignore X-free din whenever push is low.

Reset
REQ-027 While rst is high at a clock edge, SHALL set count=0, overflow=0 and underflow=0, overriding push, pop and err_clr.
REQ-028 After reset, SHALL output empty=1, full=0 and dout=0; array contents are not reset and SHALL never be observable while count==0.
REQ-029 Reset asserted mid-operation SHALL discard all entries in one cycle; the first push after reset SHALL be written to index 0.

Configuration
REQ-030 SHALL implement the error flag logic only when macro LIFO_STACK_ERR_EN is defined.
REQ-031 With LIFO_STACK_ERR_EN defined, overflow and underflow SHALL behave per REQ-013/014/020-022/025.
REQ-032 Without LIFO_STACK_ERR_EN, overflow and underflow SHALL be constant 0 and err_clr SHALL be ignored; all other behaviour SHALL be identical.

Verification (WIDTH=8, DEPTH=4, LIFO_STACK_ERR_EN defined unless stated)
REQ-033 Reset, then push 0x11, 0x22, 0x33 -> count=3; dout=0x33; empty=0; full=0.
REQ-034 From REQ-033, pop three times -> dout=0x33, then 0x22, then 0x11 in the pop cycles; then count=0, empty=1, dout=0, underflow=0.
REQ-035 Push 0xA0..0xA3 (full=1), then push 0xFF -> count=4; dout=0xA3; overflow=1; err_clr pulse -> overflow=0.
REQ-036 With count=2 and top=0x22, push+pop with din=0x5A -> count=2; dout=0x5A; next pop -> dout=0x5A, then top becomes the prior lower entry.
REQ-037 Empty, push+pop with din=0x77 -> count=1; dout=0x77; underflow=1. Repeat without LIFO_STACK_ERR_EN -> underflow stays 0.
REQ-038 With count=3, assert rst together with push -> next cycle count=0, empty=1, flags=0; then push 0x44 -> dout=0x44, count=1.
